// File: rtl/alu_pkg.sv
// alu_pkg: command codes and flag bit positions shared by the ALU pipeline.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SL  = 4'd5;
  localparam logic [3:0] ALU_SR  = 4'd6;
  localparam logic [3:0] ALU_SRU = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // Pack individual status bits into the 4-bit flags word.
  function automatic logic [3:0] mk_flags(input logic n, input logic z,
                                          input logic c, input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_N] = n;
    f[FLG_Z] = z;
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add unsigned multiplier, one partial product per cycle.
// The accumulator low half starts as the multiplier and shifts right as the
// product grows in from the top. done is asserted in the cycle whose step
// completes the product, so prod_lo/prod_hi_nz are taken from the
// next-state accumulator and the consumer registers them on that edge.
module alu_mul_seq #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_hi_nz
);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [SHW:0]       cnt;
  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] acc_nxt;

  // One shift-add step: add multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  always_comb begin
    psum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_nxt = {psum, acc[WIDTH-1:1]};
  end

  assign done       = (cnt == (SHW+1)'(1));
  assign prod_lo    = acc_nxt[WIDTH-1:0];
  assign prod_hi_nz = |acc_nxt[2*WIDTH-1:WIDTH];

  // Load operands on start, then step WIDTH times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (start) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
      cnt   <= (SHW+1)'(WIDTH);
    end else if (cnt != '0) begin
      acc   <= acc_nxt;
      cnt   <= cnt - (SHW+1)'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshake and {N,Z,C,V} flags.
// Optional sequential multiplier on cmd 8 when ALU_MUL_EN is defined;
// otherwise cmd 8 is treated as an invalid code.
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       cmd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;

  logic             fire_in;
  logic             busy;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_hnz;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] res;
  logic             c_res;
  logic             v_res;
  logic             big;
  logic [SHW-1:0]   sh;

  assign in_ready = !busy && (!out_valid || out_ready);
  assign fire_in  = in_valid && in_ready;
  // Any set bit above the shift field means the shift runs off the end.
  assign big      = |(b >> SHW);
  assign sh       = b[SHW-1:0];

  // Single-cycle operation mux.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    dif   = {1'b0, a} - {1'b0, b};
    res   = '0;
    c_res = 1'b0;
    v_res = 1'b0;
    case (cmd)
      ALU_ADD: begin
        res   = sum[MSB:0];
        c_res = sum[WIDTH];
        v_res = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        res   = dif[MSB:0];
        c_res = dif[WIDTH];
        v_res = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
      end
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_SL:  res = big ? '0 : (a << sh);
      ALU_SR:  res = big ? {WIDTH{a[MSB]}} : WIDTH'($signed(a) >>> sh);
      ALU_SRU: res = big ? '0 : (a >> sh);
      default: res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  assign mul_start = fire_in && (cmd == ALU_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (mul_start),
    .a          (a),
    .b          (b),
    .done       (mul_done),
    .prod_lo    (mul_lo),
    .prod_hi_nz (mul_hnz)
  );

  // busy covers the multiplier run; it drops on the edge the product lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         busy <= 1'b0;
    else if (mul_start) busy <= 1'b1;
    else if (mul_done)  busy <= 1'b0;
  end
`else
  assign mul_start = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_lo    = '0;
  assign mul_hnz   = 1'b0;
  assign busy      = 1'b0;
`endif

  // Result register: load on accept or multiplier completion, hold under
  // back-pressure, drop valid once consumed. A MUL accept can only happen
  // when the register is free or being drained, so it falls to the drain arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      r         <= '0;
      flags     <= '0;
    end else if (fire_in && !mul_start) begin
      out_valid <= 1'b1;
      r         <= res;
      flags     <= mk_flags(res[MSB], res == '0, c_res, v_res);
    end else if (mul_done) begin
      out_valid <= 1'b1;
      r         <= mul_lo;
      flags     <= mk_flags(mul_lo[MSB], mul_lo == '0, mul_hnz, 1'b0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed literal checks plus randomized traffic against a
// behavioural reference model; a negedge process compares every cycle.
module tb_alu_pipe;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [3:0]  cmd = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] r;
  logic [3:0]  flags;

  int nchk = 0;
  int nerr = 0;

  alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cmd(cmd), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result {r[15:0], N, Z, C, V} from plain integer arithmetic.
  function automatic logic [19:0] ref_op(input logic [3:0] c, input logic [15:0] x, input logic [15:0] y);
    int ux, uy, sx, sy, t, s;
    longint p;
    logic [15:0] res;
    logic cf, vf;
    ux = int'(x); uy = int'(y);
    sx = $signed(x); sy = $signed(y);
    res = '0; cf = 1'b0; vf = 1'b0;
    case (c)
      4'd0: begin t = ux + uy; res = t[15:0]; cf = (t > 65535);
                  s = sx + sy; vf = (s > 32767) || (s < -32768); end
      4'd1: begin t = ux - uy; res = t[15:0]; cf = (ux < uy);
                  s = sx - sy; vf = (s > 32767) || (s < -32768); end
      4'd2: res = x & y;
      4'd3: res = x | y;
      4'd4: res = x ^ y;
      4'd5: begin t = (uy >= 16) ? 0 : (ux << uy); res = t[15:0]; end
      4'd6: begin t = (uy >= 16) ? ((sx < 0) ? -1 : 0) : (sx >>> uy); res = t[15:0]; end
      4'd7: begin t = (uy >= 16) ? 0 : (ux >> uy); res = t[15:0]; end
      4'd8: if (MUL_EN) begin
              p = longint'(ux) * longint'(uy);
              res = p[15:0];
              cf = (p >= 65536);
            end
      default: res = '0;
    endcase
    return {res, res[15], (res == 16'h0), cf, vf};
  endfunction

  // Behavioural model of the output register and multiplier wait.
  logic        m_valid;
  logic [15:0] m_r, m_pr;
  logic [3:0]  m_f, m_pf;
  int          m_cnt;

  function automatic logic m_ready();
    return (m_cnt == 0) && (!m_valid || out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_r <= '0; m_f <= '0; m_cnt <= 0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin m_valid <= 1'b1; m_r <= m_pr; m_f <= m_pf; end
    end else if (in_valid && m_ready()) begin
      if (MUL_EN && cmd == 4'd8) begin
        m_cnt <= 16; {m_pr, m_pf} <= ref_op(cmd, a, b); m_valid <= 1'b0;
      end else begin
        m_valid <= 1'b1; {m_r, m_f} <= ref_op(cmd, a, b);
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("r", 32'(r), 32'(m_r));
        chk("flags", 32'(flags), 32'(m_f));
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one op from idle, measure latency, compare against literals.
  task automatic dir_op(input string nm, input logic [3:0] c, input logic [15:0] aa,
                        input logic [15:0] bb, input logic [15:0] er, input logic [3:0] ef,
                        input int elat);
    int lat;
    idle(20);
    chk({nm, "_rdy"}, 32'(in_ready), 32'd1);
    cmd = c; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (c == 4'd8) chk({nm, "_busy_rdy"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_r"}, 32'(r), 32'(er));
    chk({nm, "_flags"}, 32'(flags), 32'(ef));
  endtask

  initial begin
    logic [19:0] e;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    dir_op("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1);
    dir_op("sub_brw", 4'd1, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010, 1);
    dir_op("sr4",     4'd6, 16'h8000, 16'd4,    16'hF800, 4'b1000, 1);
    dir_op("sru4",    4'd7, 16'h8000, 16'd4,    16'h0800, 4'b0000, 1);
    dir_op("sl16",    4'd5, 16'h0001, 16'd16,   16'h0000, 4'b0100, 1);
    dir_op("sr20",    4'd6, 16'h8000, 16'd20,   16'hFFFF, 4'b1000, 1);
    dir_op("cmd12",   4'd12, 16'h1234, 16'h5678, 16'h0000, 4'b0100, 1);
    if (MUL_EN) begin
      dir_op("mul1",  4'd8, 16'h0123, 16'h0010, 16'h1230, 4'b0000, 17);
      dir_op("mul2",  4'd8, 16'h1000, 16'h0010, 16'h0000, 4'b0110, 17);
    end else begin
      dir_op("cmd8",  4'd8, 16'h0123, 16'h0010, 16'h0000, 4'b0100, 1);
    end

    // Back-pressure: hold one ADD result for 5 cycles.
    idle(20);
    cmd = 4'd0; a = 16'd3; b = 16'd4; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_r", 32'(r), 32'd7);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    // Ten back-to-back ops, one result per cycle in order.
    for (int i = 0; i < 10; i++) begin
      cmd = 4'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom_range(0, 18));
      e = ref_op(cmd, a, b);
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_r", 32'(r), 32'(e[19:4]));
      chk("b2b_flags", 32'(flags), 32'(e[3:0]));
    end
    in_valid = 1'b0;

    // Reset in the middle of a multiply: no result may appear afterwards.
    if (MUL_EN) begin
      idle(20);
      cmd = 4'd8; a = 16'd5; b = 16'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mulrst_valid", 32'(out_valid), 32'd0);
      chk("mulrst_rdy", 32'(in_ready), 32'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (20) begin
        chk("mulrst_noresult", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
      end
    end

    // Randomized traffic, with an asynchronous reset dropped in mid-stream.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cmd = 4'($urandom_range(0, 15));
      a   = 16'($urandom);
      b   = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if (i == 700) begin
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_r", 32'(r), 32'd0);
        chk("midrst_flags", 32'(flags), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        chk("midrst_rdy", 32'(in_ready), 32'd1);
      end
      @(posedge clk); #1;
    end
    idle(20);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
